// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Hits complete in the access cycle; misses stall the pipeline and run a line refill.
module dcache_controller #(
    parameter int INDEX_BITS = 4,
    parameter int LINE_BITS  = 256,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e                 state_q, state_d;
    logic [LINES-1:0]       valid_q, dirty_q;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [LINE_BITS-1:0]   data_q [LINES];
    logic [31:0]            hit_count_q, miss_count_q;
    logic                   refill_q;

    logic [2:0]             word;
    logic [INDEX_BITS-1:0]  index;
    logic [TAG_BITS-1:0]    req_tag;
    logic [LINE_BITS-1:0]   line_sel;
    logic                   hit, miss, alloc_ack;
    logic                   unused_addr;

    assign word        = cpu_addr_i[4:2];
    assign index       = cpu_addr_i[4+INDEX_BITS:5];
    assign req_tag     = cpu_addr_i[31:5+INDEX_BITS];
    assign unused_addr = ^cpu_addr_i[1:0];
    assign line_sel    = data_q[index];

    assign hit       = (state_q == IDLE) && cpu_req_i && valid_q[index] && (tag_q[index] == req_tag);
    assign miss      = (state_q == IDLE) && cpu_req_i && !hit;
    assign alloc_ack = (state_q == ALLOCATE) && mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (miss) state_d = (valid_q[index] && dirty_q[index]) ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
            ALLOCATE:  if (mem_ack_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // The CPU holds its address during a miss, so index/tag stay valid for the whole transaction.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        case (state_q)
            IDLE: begin
                cpu_stall_o = miss;
                if (hit && !cpu_we_i) cpu_data_o = line_sel[{word, 5'b0} +: 32];
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[index], index, 5'b0};
                mem_data_o   = line_sel;
            end
            ALLOCATE: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, index, 5'b0};
            end
            default: ;
        endcase
    end

    // refill_q marks the replay cycle that follows a refill so it is not counted as a hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            dirty_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            refill_q     <= 1'b0;
        end else begin
            refill_q <= alloc_ack;
            if (miss)              miss_count_q <= miss_count_q + 32'd1;
            if (hit && !refill_q)  hit_count_q  <= hit_count_q + 32'd1;
            if (hit && cpu_we_i)   dirty_q[index] <= 1'b1;
            if (alloc_ack) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; cleared valid bits make their contents unreachable.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (hit && cpu_we_i) data_q[index][{word, 5'b0} +: 32] <= cpu_data_i;
            if (alloc_ack) begin
                data_q[index] <= mem_data_i;
                tag_q[index]  <= req_tag;
            end
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller: hits, clean/dirty misses,
// write-allocate, reset during a refill and hit counter wrap.
module tb_dcache_controller;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o, hit_count_o, miss_count_o;
    logic [255:0] mem_data_o, mem_data_i;

    int n_checks = 0;
    int n_errors = 0;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one CPU cycle at the falling edge and let combinational outputs settle.
    task automatic cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        cpu_req_i  = req;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        #1;
    endtask

    // Memory model: acks each phase 'delay' cycles after its enable first goes high.
    // Entered in the miss-detect cycle; returns in the replay cycle.
    task automatic run_miss(input int wb_delay, input int rd_delay, input logic [255:0] rline,
                            output int stalls, output logic saw_wb, output logic [31:0] wb_addr,
                            output logic [255:0] wb_data, output logic [31:0] rd_addr);
        int   cnt = 0;
        logic in_phase = 1'b0;
        logic phase_wr = 1'b0;
        stalls = 0; saw_wb = 1'b0; wb_addr = '0; wb_data = '0; rd_addr = '0;
        for (int cyc = 0; cyc < 200 && cpu_stall_o; cyc++) begin
            stalls++;
            if (mem_enable_o) begin
                if (!in_phase || phase_wr != mem_write_o) begin
                    in_phase = 1'b1;
                    phase_wr = mem_write_o;
                    cnt      = 0;
                    if (mem_write_o) begin
                        saw_wb  = 1'b1;
                        wb_addr = mem_addr_o;
                        wb_data = mem_data_o;
                    end else begin
                        rd_addr = mem_addr_o;
                    end
                end
                if (cnt == (mem_write_o ? wb_delay : rd_delay)) begin
                    mem_ack_i = 1'b1;
                    if (!mem_write_o) mem_data_i = rline;
                end
                cnt++;
            end
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            #1;
        end
        if (cpu_stall_o) check("miss_timeout_stall", {31'b0, cpu_stall_o}, 32'd0);
    endtask

    logic [255:0] line1, line2, line3, line4, line5, wb_data;
    logic [31:0]  wb_addr, rd_addr;
    logic         saw_wb;
    int           stalls;

    initial begin
        for (int i = 0; i < 8; i++) begin
            line1[i*32 +: 32] = 32'h1000_0000 + i;
            line2[i*32 +: 32] = 32'h2000_0000 + i;
            line3[i*32 +: 32] = 32'h3000_0000 + i;
            line4[i*32 +: 32] = 32'h4000_0000 + i;
            line5[i*32 +: 32] = 32'h5000_0000 + i;
        end
        line1[31:0]  = 32'hDEAD_BEEF;
        line1[63:32] = 32'hCAFE_F00D;

        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_stall",  {31'b0, cpu_stall_o},  32'd0);
        check("rst_enable", {31'b0, mem_enable_o}, 32'd0);
        check("rst_write",  {31'b0, mem_write_o},  32'd0);
        check("rst_addr",   mem_addr_o,            32'd0);
        check("rst_mdata",  mem_data_o[31:0],      32'd0);
        check("rst_cdata",  cpu_data_o,            32'd0);
        check("rst_hits",   hit_count_o,           32'd0);
        check("rst_misses", miss_count_o,          32'd0);

        // Clean miss on index 2, ack 10 cycles after enable -> 12 stall cycles.
        cpu(1'b1, 1'b0, 32'h0000_0040, '0);
        check("m1_detect_stall",  {31'b0, cpu_stall_o},  32'd1);
        check("m1_detect_enable", {31'b0, mem_enable_o}, 32'd0);
        run_miss(0, 10, line1, stalls, saw_wb, wb_addr, wb_data, rd_addr);
        check("m1_stalls",  stalls,              32'd12);
        check("m1_no_wb",   {31'b0, saw_wb},     32'd0);
        check("m1_rd_addr", rd_addr,             32'h0000_0040);
        check("m1_data",    cpu_data_o,          32'hDEAD_BEEF);
        cpu(1'b0, 1'b0, '0, '0);
        check("m1_misses",  miss_count_o,        32'd1);
        check("m1_hits",    hit_count_o,         32'd0);

        // Read hit on word 1, same-cycle data.
        cpu(1'b1, 1'b0, 32'h0000_0044, '0);
        check("h1_stall", {31'b0, cpu_stall_o}, 32'd0);
        check("h1_data",  cpu_data_o,           32'hCAFE_F00D);
        cpu(1'b0, 1'b0, '0, '0);
        check("h1_hits",  hit_count_o,          32'd1);

        // Store hit to word 0 marks the line dirty; no load data on a store.
        cpu(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
        check("s1_stall", {31'b0, cpu_stall_o}, 32'd0);
        check("s1_cdata", cpu_data_o,           32'd0);
        cpu(1'b0, 1'b0, '0, '0);
        check("s1_hits",  hit_count_o,          32'd2);

        // Conflict miss on index 2: write-back of the dirty line, then refill.
        cpu(1'b1, 1'b0, 32'h0000_0240, '0);
        run_miss(3, 4, line2, stalls, saw_wb, wb_addr, wb_data, rd_addr);
        check("m2_saw_wb",   {31'b0, saw_wb},   32'd1);
        check("m2_wb_addr",  wb_addr,           32'h0000_0040);
        check("m2_wb_w0",    wb_data[31:0],     32'h1234_5678);
        check("m2_wb_w1",    wb_data[63:32],    32'hCAFE_F00D);
        check("m2_rd_addr",  rd_addr,           32'h0000_0240);
        check("m2_stalls",   stalls,            32'd10);
        check("m2_data",     cpu_data_o,        32'h2000_0000);
        cpu(1'b0, 1'b0, '0, '0);
        check("m2_misses",   miss_count_o,      32'd2);
        check("m2_hits",     hit_count_o,       32'd2);

        // Invalid line, clean victim: no write-back phase.
        cpu(1'b1, 1'b0, 32'h0000_0068, '0);
        run_miss(0, 2, line3, stalls, saw_wb, wb_addr, wb_data, rd_addr);
        check("m3_no_wb",   {31'b0, saw_wb}, 32'd0);
        check("m3_stalls",  stalls,          32'd4);
        check("m3_rd_addr", rd_addr,         32'h0000_0060);
        check("m3_data",    cpu_data_o,      32'h3000_0002);

        // Store miss: write-allocate, the replay merges the store word.
        cpu(1'b1, 1'b1, 32'h0000_0080, 32'hA5A5_0001);
        run_miss(0, 1, line4, stalls, saw_wb, wb_addr, wb_data, rd_addr);
        check("m4_stalls", stalls,               32'd3);
        check("m4_stall",  {31'b0, cpu_stall_o}, 32'd0);
        cpu(1'b1, 1'b0, 32'h0000_0080, '0);
        check("m4_merged", cpu_data_o,           32'hA5A5_0001);
        cpu(1'b1, 1'b0, 32'h0000_0084, '0);
        check("m4_refill", cpu_data_o,           32'h4000_0001);
        cpu(1'b0, 1'b0, '0, '0);
        check("m4_misses", miss_count_o,         32'd4);
        check("m4_hits",   hit_count_o,          32'd4);

        // Reset while a refill is outstanding; the late ack must be ignored.
        cpu(1'b1, 1'b0, 32'h0000_0100, '0);
        check("r_detect", {31'b0, cpu_stall_o}, 32'd1);
        @(negedge clk_i); #1;
        check("r_alloc_enable", {31'b0, mem_enable_o}, 32'd1);
        check("r_alloc_addr",   mem_addr_o,            32'h0000_0100);
        rst_i = 1'b1; cpu_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0; #1;
        check("r_enable", {31'b0, mem_enable_o}, 32'd0);
        check("r_stall",  {31'b0, cpu_stall_o},  32'd0);
        check("r_misses", miss_count_o,          32'd0);
        @(negedge clk_i);
        mem_ack_i = 1'b1; mem_data_i = '1; #1;
        check("r_ack_enable", {31'b0, mem_enable_o}, 32'd0);
        @(negedge clk_i);
        mem_ack_i = 1'b0; #1;
        check("r_post_enable", {31'b0, mem_enable_o}, 32'd0);
        check("r_post_stall",  {31'b0, cpu_stall_o},  32'd0);
        cpu(1'b1, 1'b0, 32'h0000_0040, '0);
        check("r_old_line_miss", {31'b0, cpu_stall_o}, 32'd1);
        run_miss(0, 0, line1, stalls, saw_wb, wb_addr, wb_data, rd_addr);
        check("r_old_line_data", cpu_data_o, 32'hDEAD_BEEF);
        cpu(1'b1, 1'b0, 32'h0000_0100, '0);
        check("r_same_line_miss", {31'b0, cpu_stall_o}, 32'd1);
        run_miss(0, 1, line5, stalls, saw_wb, wb_addr, wb_data, rd_addr);
        check("r_stalls", stalls,     32'd3);
        check("r_data",   cpu_data_o, 32'h5000_0000);
        cpu(1'b0, 1'b0, '0, '0);
        check("r_misses2", miss_count_o, 32'd2);
        check("r_hits",    hit_count_o,  32'd0);

        // Hit counter wrap, preloaded through the hierarchy.
        force dut.hit_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_count_q;
        #1;
        check("wrap_pre", hit_count_o, 32'hFFFF_FFFF);
        cpu(1'b1, 1'b0, 32'h0000_0104, '0);
        check("wrap_data", cpu_data_o, 32'h5000_0001);
        cpu(1'b0, 1'b0, '0, '0);
        check("wrap_hits",   hit_count_o,  32'd0);
        check("wrap_misses", miss_count_o, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
